bmc_soft_punct: RTL and testbench



---
 rtl/bmc_pkg.sv | 22 ++
 rtl/bmc_min_tree.sv | 24 ++
 rtl/bmc_soft_punct.sv | 118 +++++++++++
 tb/tb_bmc_soft_punct.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bmc_pkg.sv
// bmc_pkg: width helpers, stage-valid type (widened by BMC_NORM_EN) and the rate-2/3 puncture pattern
package bmc_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int bm_width(input int n, input int w);
    return clog2(n * ((1 << w) - 1) + 1);
  endfunction
  function automatic int ph_width(input int p);
    return p > 1 ? clog2(p) : 1;
  endfunction
`ifdef BMC_NORM_EN
  localparam int NSTG = 3;
`else
  localparam int NSTG = 2;
`endif
  typedef logic [NSTG-1:0] stage_vld_t;
  localparam logic [3:0] PAT_R23 = {2'b01, 2'b11};
endpackage

// File: rtl/bmc_min_tree.sv
// bmc_min_tree: pairwise minimum over 2^N_OUT metrics; in_bm packed metrics -> min_bm smallest one
module bmc_min_tree #(
  parameter int N_OUT = 2,
  parameter int BM_W = 4
) (
  input  logic [(1<<N_OUT)*BM_W-1:0] in_bm,
  output logic [BM_W-1:0]            min_bm
);
  localparam int NC = 1 << N_OUT;
  for (genvar l = 0; l <= N_OUT; l++) begin : g_l
    logic [(NC>>l)*BM_W-1:0] m;
    if (l == 0) begin : g_leaf
      assign m = in_bm;
    end else begin : g_node
      for (genvar k = 0; k < (NC >> l); k++) begin : g_k
        logic [BM_W-1:0] a, b;
        assign a = g_l[l-1].m[2*k*BM_W +: BM_W];
        assign b = g_l[l-1].m[(2*k+1)*BM_W +: BM_W];
        assign m[k*BM_W +: BM_W] = a < b ? a : b;
      end
    end
  end
  assign min_bm = g_l[N_OUT].m;
endmodule

// File: rtl/bmc_soft_punct.sv
// bmc_soft_punct: punctured soft branch metrics; in_* valid/ready symbols -> out_bm per codeword with out_phase/out_sof; BMC_NORM_EN adds min-normalising stage
module bmc_soft_punct
  import bmc_pkg::*;
#(
  parameter int N_OUT = 2,
  parameter int SOFT_W = 3,
  parameter int PUNCT_LEN = 1,
  parameter logic [N_OUT*PUNCT_LEN-1:0] PUNCT_PAT = '1,
  localparam int NC = 1 << N_OUT,
  localparam int BM_W = bm_width(N_OUT, SOFT_W),
  localparam int PH_W = ph_width(PUNCT_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_OUT*SOFT_W-1:0] in_sym,
  input  logic [N_OUT-1:0]        in_erase,
  input  logic                    in_sof,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NC*BM_W-1:0]      out_bm,
  output logic [PH_W-1:0]         out_phase,
  output logic                    out_sof
);
  localparam logic [SOFT_W-1:0] SMAX = '1;
  stage_vld_t v;
  logic [PH_W-1:0] cnt, ph, s1_ph, s2_ph;
  logic [N_OUT*SOFT_W-1:0] s1_sym;
  logic [N_OUT-1:0] s1_mask;
  logic [N_OUT-1:0] pm [2**PH_W];
  logic s1_sof, s2_sof, s2_load;
  logic [NC*BM_W-1:0] bm, s2_bm;
`ifdef BMC_NORM_EN
  logic s3_load, s3_sof;
  logic [BM_W-1:0] mn;
  logic [NC*BM_W-1:0] nbm, s3_bm;
  logic [PH_W-1:0] s3_ph;
  assign s3_load = !v[2] | out_ready;
  assign s2_load = !v[1] | s3_load;
  bmc_min_tree #(.N_OUT(N_OUT), .BM_W(BM_W)) u_min (.in_bm(s2_bm), .min_bm(mn));
  for (genvar c = 0; c < NC; c++) begin : g_n
    assign nbm[c*BM_W +: BM_W] = s2_bm[c*BM_W +: BM_W] - mn;
  end
  assign out_valid = v[2];
  assign out_bm = s3_bm;
  assign out_phase = s3_ph;
  assign out_sof = s3_sof;
`else
  assign s2_load = !v[1] | out_ready;
  assign out_valid = v[1];
  assign out_bm = s2_bm;
  assign out_phase = s2_ph;
  assign out_sof = s2_sof;
`endif
  assign in_ready = !v[0] | s2_load;
  assign ph = in_sof ? '0 : cnt;
  for (genvar p = 0; p < 2**PH_W; p++) begin : g_p
    if (p < PUNCT_LEN) begin : g_v
      assign pm[p] = PUNCT_PAT[p*N_OUT +: N_OUT];
    end else begin : g_x
      assign pm[p] = '1;
    end
  end
  // symbols padded to four slots so every metric is a fixed four-term sum
  for (genvar c = 0; c < NC; c++) begin : g_c
    logic [4*BM_W-1:0] cst;
    for (genvar i = 0; i < 4; i++) begin : g_i
      if (i < N_OUT) begin : g_s
        assign cst[i*BM_W +: BM_W] = s1_mask[i] ? '0 :
          BM_W'(((c >> i) & 1) == 1 ? SMAX - s1_sym[i*SOFT_W +: SOFT_W] : s1_sym[i*SOFT_W +: SOFT_W]);
      end else begin : g_z
        assign cst[i*BM_W +: BM_W] = '0;
      end
    end
    assign bm[c*BM_W +: BM_W] = cst[0 +: BM_W] + cst[BM_W +: BM_W] + cst[2*BM_W +: BM_W] + cst[3*BM_W +: BM_W];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      cnt <= '0;
      s1_sym <= '0;
      s1_mask <= '0;
      s1_ph <= '0;
      s1_sof <= 1'b0;
      s2_bm <= '0;
      s2_ph <= '0;
      s2_sof <= 1'b0;
`ifdef BMC_NORM_EN
      s3_bm <= '0;
      s3_ph <= '0;
      s3_sof <= 1'b0;
`endif
    end else begin
      if (in_ready) v[0] <= in_valid;
      if (in_valid & in_ready) begin
        cnt <= (ph == PH_W'(PUNCT_LEN - 1)) ? '0 : ph + PH_W'(1);
        s1_sym <= in_sym;
        s1_mask <= in_erase | ~pm[ph];
        s1_ph <= ph;
        s1_sof <= in_sof;
      end
      if (s2_load) v[1] <= v[0];
      if (s2_load & v[0]) begin
        s2_bm <= bm;
        s2_ph <= s1_ph;
        s2_sof <= s1_sof;
      end
`ifdef BMC_NORM_EN
      if (s3_load) v[2] <= v[1];
      if (s3_load & v[1]) begin
        s3_bm <= nbm;
        s3_ph <= s2_ph;
        s3_sof <= s2_sof;
      end
`endif
    end
endmodule

// File: tb/tb_bmc_soft_punct.sv
// tb_bmc_soft_punct: scoreboard bench; main DUT punctured rate 2/3 soft, aux DUT hard-decision latency probe
module tb_bmc_soft_punct;
`ifdef BMC_NORM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_sof, out_phase;
  logic [5:0] in_sym = '0;
  logic [1:0] in_erase = '0;
  logic [15:0] out_bm;
  logic a_valid = 1'b0, a_ready, a_ovalid, a_osof, a_ph;
  logic [1:0] a_sym = '0;
  logic [7:0] a_bm;
  int checks = 0, fails = 0;
  logic [17:0] q[$];
  logic [17:0] held, e;
  logic hold_v = 1'b0;
  logic [3:0] rpat = 4'b1111;
  int rk = 0;

  bmc_soft_punct #(.N_OUT(2), .SOFT_W(3), .PUNCT_LEN(2), .PUNCT_PAT(4'b0111)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .in_erase(in_erase), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .out_bm(out_bm), .out_phase(out_phase), .out_sof(out_sof));

  bmc_soft_punct #(.N_OUT(2), .SOFT_W(1)) aux (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_sym(a_sym),
    .in_erase(2'b00), .in_sof(1'b0), .out_valid(a_ovalid), .out_ready(1'b1),
    .out_bm(a_bm), .out_phase(a_ph), .out_sof(a_osof));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] norm(input logic [15:0] b);
`ifdef BMC_NORM_EN
    logic [3:0] m;
    m = b[3:0];
    for (int k = 1; k < 4; k++) if (b[k*4 +: 4] < m) m = b[k*4 +: 4];
    for (int k = 0; k < 4; k++) b[k*4 +: 4] = b[k*4 +: 4] - m;
`endif
    return b;
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rpat[rk % 4];
    rk++;
  end

  always @(negedge clk) begin
    if (rst) hold_v <= 1'b0;
    else begin
      if (hold_v) chk("stall_hold", 32'({out_valid, out_sof, out_phase, out_bm}), 32'({1'b1, held}));
      if (out_ready || !out_valid) chk("in_ready", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out: got bm 0x%0h with nothing expected", out_bm);
        end else begin
          e = q.pop_front();
          chk("out_bm", 32'(out_bm), 32'(e[15:0]));
          chk("out_phase", 32'(out_phase), 32'(e[16]));
          chk("out_sof", 32'(out_sof), 32'(e[17]));
        end
      end
      hold_v <= out_valid && !out_ready;
      held <= {out_sof, out_phase, out_bm};
    end
  end

  task automatic send(input logic [5:0] s, input logic [1:0] er, input logic sof, input logic ph, input logic [15:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sym = s;
    in_erase = er;
    in_sof = sof;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, want accept", n);
    end else q.push_back({sof, ph, norm(b)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof = 1'b0;
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats outstanding, want 0", q.size());
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bm", 32'(out_bm), 32'd0);
    chk("rst_out_phase", 32'(out_phase), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    send(6'o07, 2'b00, 1'b1, 1'b0, 16'h7E07);
    send(6'o77, 2'b00, 1'b1, 1'b0, 16'h077E);
    send(6'o77, 2'b00, 1'b0, 1'b1, 16'h0707);
    send(6'o77, 2'b00, 1'b0, 1'b0, 16'h077E);
    send(6'o07, 2'b01, 1'b1, 1'b0, 16'h7700);
    send(6'o53, 2'b11, 1'b0, 1'b1, 16'h0000);
    send(6'o53, 2'b00, 1'b1, 1'b0, 16'h6598);
    idle(1);
    @(posedge clk);
    #1 in_sof = 1'b1;
    @(posedge clk);
    #1 in_sof = 1'b0;
    send(6'o07, 2'b00, 1'b0, 1'b1, 16'h0707);
    idle(1);
    drain();
    rpat = 4'b1001;
    rk = 0;
    send(6'o07, 2'b00, 1'b1, 1'b0, 16'h7E07);
    send(6'o77, 2'b00, 1'b0, 1'b1, 16'h0707);
    send(6'o53, 2'b00, 1'b0, 1'b0, 16'h6598);
    send(6'o07, 2'b00, 1'b0, 1'b1, 16'h0707);
    send(6'o77, 2'b00, 1'b0, 1'b0, 16'h077E);
    send(6'o53, 2'b00, 1'b0, 1'b1, 16'h4343);
    send(6'o07, 2'b10, 1'b0, 1'b0, 16'h0707);
    send(6'o77, 2'b11, 1'b0, 1'b1, 16'h0000);
    idle(1);
    drain();
    rpat = 4'b1111;
    send(6'o53, 2'b00, 1'b1, 1'b0, 16'h6598);
    idle(1);
    drain();
    rpat = 4'b0000;
    send(6'o77, 2'b00, 1'b0, 1'b1, 16'h0707);
    send(6'o07, 2'b00, 1'b0, 1'b0, 16'h7E07);
    idle(3);
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rpat = 4'b1111;
    idle(6);
    send(6'o77, 2'b00, 1'b0, 1'b0, 16'h077E);
    idle(1);
    drain();
    @(posedge clk);
    #1 a_valid = 1'b1;
    a_sym = 2'b01;
    @(negedge clk);
    chk("aux_in_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!a_ovalid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("aux_latency", 32'(n), 32'(LAT));
    chk("aux_bm", 32'(a_bm), 32'h61);
    chk("aux_phase", 32'(a_ph), 32'd0);
    chk("aux_sof", 32'(a_osof), 32'd0);
    @(negedge clk);
    chk("aux_single", 32'(a_ovalid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
